con_feed_ctrl: RTL and testbench
================================

Name: con_feed_ctrl

Overview:
Sequencer that sits between the host/load path and the con_5x5 convolution engine. It buffers one 3x3 kernel and one 7x7 frame, then streams them to the engine as one continuous eng_ena burst: the 9 kernel words, then 81 pixel words in serpentine column-triple order. It then collects the 25 results and signals completion. Kernel reuse across frames is supported, so a frame without a kernel load uses an 81-word burst instead of 90.

Parameters:
DW, 16, data/result width
DRAIN_MAX, 255, max cycles in DRAIN waiting for engine completion before error abort

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  host buffer write strobe
wr_addr  in  6  0-8 kernel row-major (k11..k33); 9-57 pixel row-major, pixel[r][c] at 9+7*(r-1)+(c-1)
wr_data  in  DW  write data
start  in  1  one-cycle pulse; begin a frame
reuse_kernel  in  1  sampled with start; 1 = skip kernel phase
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
err  out  1  sticky timeout flag; cleared by next accepted start
eng_ena  out  1  engine enable
eng_data  out  DW  engine input word
eng_valid  in  1  engine result strobe
eng_result  in  DW  engine result
eng_finish  in  1  engine frame-complete
res_valid  out  1  one-cycle pulse per captured result
res_data  out  DW  captured result
res_idx  out  5  result index 0-24
rd_addr  in  5  result buffer read address (feature only)
rd_data  out  DW  result buffer read data (feature only)

Behaviour:
- Reset values: busy, done, err, eng_ena, res_valid = 0; eng_data, res_data, res_idx, rd_data = 0. kernel_loaded = 0; buffer contents are not reset.
- Storage: 58 x DW register array. Writes with wr_addr > 57 are ignored. Writes while busy=1 are ignored. A write to any of addresses 0-8 sets kernel_loaded.
- FSM states: IDLE, KERNEL, PIXEL, DRAIN, DONE.
- IDLE -> KERNEL on start when (reuse_kernel=0 or kernel_loaded=0).
- IDLE -> PIXEL on start when reuse_kernel=1 and kernel_loaded=1.
- start is ignored outside IDLE.
- Latency: start accepted at edge k -> busy=1, eng_ena=1 and the first word on eng_data from edge k+1. All engine outputs are registered.
- KERNEL: 9 cycles sending addresses 0..8, then PIXEL with no gap.
- PIXEL: 81 cycles. Window row w=1..5.
  - w=1: columns c=1..7, each sends p[1][c], p[2][c], p[3][c] (21 words).
  - Even w: sends p[w+2][5], p[w+2][6], p[w+2][7]; then for c=4 down to 1, sends p[w][c], p[w+1][c], p[w+2][c].
  - Odd w>=3: sends p[w+2][1], p[w+2][2], p[w+2][3]; then for c=4..7, sends p[w][c], p[w+1][c], p[w+2][c].
  - Each w>=2 is 15 words.
  - Implemented with word (0-2), group and window-row counters; no stored address table.
- After the last pixel: eng_ena=0 and eng_data holds its last value; enter DRAIN. The burst is 90 cycles with kernel, 81 without.
- Result capture (any state except IDLE): each cycle with eng_valid=1 and eng_valid=0 the previous cycle (rising edge) captures eng_result.
  - res_data, res_idx and a res_valid pulse appear one cycle later.
  - res_idx increments modulo 25 and resets to 0 on accepted start.
  - Rising edges beyond the 25th in a frame are ignored.
- DRAIN -> DONE when eng_finish=1 or 25 results have been captured.
- DRAIN -> DONE with err=1 if DRAIN_MAX cycles elapse without either condition.
- DONE: one cycle, done=1; busy falls in the same cycle; -> IDLE.
- eng_finish seen during KERNEL or PIXEL is ignored.
- Synchronous reset mid-frame: at that edge all outputs return to reset values and the burst is abandoned; kernel_loaded clears.

Optional Feature:
CON_FEED_RESBUF_EN
- Defined: 25 x DW result buffer written at res_idx on capture. rd_data is a registered read of rd_addr with 1-cycle latency; rd_addr > 24 returns 0. The buffer retains contents across frames.
- Undefined: no buffer; rd_data is tied to 0 and rd_addr is unused.

Test Plan:
- Load kernel 1..9 and pixel[r][c]=16'h0rc; pulse start with reuse_kernel=0 -> eng_ena high for exactly 90 cycles starting 1 cycle after start. First words are 0001..0009, then 0011, 0021, 0031, 0012. Word 22 of the pixel phase is 0045; word 37 is 0051.
- Second frame with reuse_kernel=1 and 7 idle cycles between frames -> 81-cycle burst starting with 0011; no kernel words sent.
- reuse_kernel=1 immediately after reset (no kernel written) -> 90-cycle burst including the kernel phase.
- Model engine emits 25 valid pulses with results 0x100+i -> res_idx 0..24 with matching res_data; done 1 cycle after the 25th capture; err=0. With CON_FEED_RESBUF_EN, rd_addr=7 returns 0x107 one cycle later.
- Engine silent after the burst with DRAIN_MAX=20 -> done and err=1 twenty cycles into DRAIN; next start clears err.
- rst_n=0 on pixel word 40 -> eng_ena=0 and busy=0 at that edge; wr_en during busy leaves the buffer unchanged; start during busy is ignored.

Source files
------------

// File: rtl/con_feed_ctrl.sv
// Feed sequencer for con_5x5: buffers a 3x3 kernel and 7x7 frame, streams them as one burst
// and collects the 25 results. Define CON_FEED_RESBUF_EN to add a readable result buffer.
module con_feed_ctrl #(
  parameter int unsigned DW        = 16,
  parameter int unsigned DRAIN_MAX = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          reuse_kernel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          eng_ena,
  output logic [DW-1:0] eng_data,
  input  logic          eng_valid,
  input  logic [DW-1:0] eng_result,
  input  logic          eng_finish,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [4:0]    res_idx,
  input  logic [4:0]    rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int unsigned DCW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

  typedef enum logic [2:0] {StIdle, StKernel, StPixel, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  buf_q [58];
  logic           kernel_loaded_q, kernel_loaded_d;
  logic [3:0]     kidx_q, kidx_d;
  logic [2:0]     win_q, win_d;
  logic [2:0]     grp_q, grp_d;
  logic [1:0]     wrd_q, wrd_d;
  logic [2:0]     last_grp;
  logic [DCW-1:0] drain_q, drain_d;
  logic [4:0]     cap_cnt_q, cap_cnt_d;
  logic           valid_prev_q;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           eng_ena_q, eng_ena_d;
  logic [DW-1:0]  eng_data_q, eng_data_d;
  logic           res_valid_q, res_valid_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic [4:0]     res_idx_q, res_idx_d;
  logic           wr_ok;
  logic           capture;

  // Buffer address of window row w, column group g, word wd (counters are zero-based except w).
  function automatic logic [5:0] pix_addr(input logic [2:0] w, input logic [2:0] g,
                                          input logic [1:0] wd);
    logic [2:0] r0;
    logic [2:0] c0;
    if (w == 3'd1) begin
      r0 = 3'(wd);
      c0 = g;
    end else if (g == 3'd0) begin
      // Leading group completes the new bottom row on the side the previous sweep ended.
      r0 = w + 3'd1;
      c0 = w[0] ? 3'(wd) : 3'd4 + 3'(wd);
    end else begin
      r0 = w - 3'd1 + 3'(wd);
      c0 = w[0] ? 3'd2 + g : 3'd4 - g;
    end
    return 6'd9 + 6'({r0, 3'b000} - {3'b000, r0}) + 6'(c0);
  endfunction

  assign wr_ok    = wr_en && !busy_q && (wr_addr < 6'd58);
  assign capture  = (state_q != StIdle) && eng_valid && !valid_prev_q && (cap_cnt_q < 5'd25);
  assign last_grp = (win_q == 3'd1) ? 3'd6 : 3'd4;

  always_comb begin
    state_d         = state_q;
    kernel_loaded_d = kernel_loaded_q;
    kidx_d          = kidx_q;
    win_d           = win_q;
    grp_d           = grp_q;
    wrd_d           = wrd_q;
    drain_d         = drain_q;
    cap_cnt_d       = cap_cnt_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = err_q;
    eng_ena_d       = eng_ena_q;
    eng_data_d      = eng_data_q;
    res_valid_d     = 1'b0;
    res_data_d      = res_data_q;
    res_idx_d       = res_idx_q;

    if (wr_ok && (wr_addr < 6'd9)) kernel_loaded_d = 1'b1;

    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = eng_result;
      res_idx_d   = cap_cnt_q;
      cap_cnt_d   = cap_cnt_q + 5'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          busy_d    = 1'b1;
          eng_ena_d = 1'b1;
          err_d     = 1'b0;
          res_idx_d = 5'd0;
          cap_cnt_d = 5'd0;
          drain_d   = '0;
          win_d     = 3'd1;
          grp_d     = 3'd0;
          wrd_d     = 2'd0;
          kidx_d    = 4'd0;
          if (reuse_kernel && kernel_loaded_q) begin
            state_d    = StPixel;
            eng_data_d = buf_q[6'd9];
          end else begin
            state_d    = StKernel;
            eng_data_d = buf_q[6'd0];
          end
        end
      end
      StKernel: begin
        if (kidx_q == 4'd8) begin
          state_d    = StPixel;
          eng_data_d = buf_q[6'd9];
        end else begin
          kidx_d     = kidx_q + 4'd1;
          eng_data_d = buf_q[{2'b00, kidx_d}];
        end
      end
      StPixel: begin
        if (win_q == 3'd5 && grp_q == 3'd4 && wrd_q == 2'd2) begin
          state_d   = StDrain;
          eng_ena_d = 1'b0;
          drain_d   = '0;
        end else begin
          if (wrd_q != 2'd2) begin
            wrd_d = wrd_q + 2'd1;
          end else begin
            wrd_d = 2'd0;
            if (grp_q != last_grp) begin
              grp_d = grp_q + 3'd1;
            end else begin
              grp_d = 3'd0;
              win_d = win_q + 3'd1;
            end
          end
          eng_data_d = buf_q[pix_addr(win_d, grp_d, wrd_d)];
        end
      end
      StDrain: begin
        if (eng_finish || (cap_cnt_q == 5'd25)) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (drain_q == DCW'(DRAIN_MAX - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      kernel_loaded_q <= 1'b0;
      kidx_q          <= 4'd0;
      win_q           <= 3'd1;
      grp_q           <= 3'd0;
      wrd_q           <= 2'd0;
      drain_q         <= '0;
      cap_cnt_q       <= 5'd0;
      valid_prev_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      eng_ena_q       <= 1'b0;
      eng_data_q      <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_idx_q       <= 5'd0;
    end else begin
      state_q         <= state_d;
      kernel_loaded_q <= kernel_loaded_d;
      kidx_q          <= kidx_d;
      win_q           <= win_d;
      grp_q           <= grp_d;
      wrd_q           <= wrd_d;
      drain_q         <= drain_d;
      cap_cnt_q       <= cap_cnt_d;
      valid_prev_q    <= eng_valid;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      eng_ena_q       <= eng_ena_d;
      eng_data_q      <= eng_data_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_idx_q       <= res_idx_d;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[wr_addr] <= wr_data;
  end

`ifdef CON_FEED_RESBUF_EN
  logic [DW-1:0] resbuf_q [25];
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (capture) resbuf_q[cap_cnt_q] <= eng_result;
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_addr < 5'd25) rd_data_d = resbuf_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign eng_ena   = eng_ena_q;
  assign eng_data  = eng_data_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_con_feed_ctrl.sv
// Bench for con_feed_ctrl: scoreboarded engine stream and results, plus spot-check vector table.
module tb_con_feed_ctrl;
  localparam int DW        = 16;
  localparam int DRAIN_MAX = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          reuse_kernel;
  logic          busy, done, err, eng_ena, res_valid;
  logic [DW-1:0] eng_data, res_data, rd_data;
  logic          eng_valid, eng_finish;
  logic [DW-1:0] eng_result;
  logic [4:0]    res_idx, rd_addr;

  always #5 clk = ~clk;

  con_feed_ctrl #(.DW(DW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .reuse_kernel(reuse_kernel), .busy(busy), .done(done), .err(err),
    .eng_ena(eng_ena), .eng_data(eng_data), .eng_valid(eng_valid), .eng_result(eng_result),
    .eng_finish(eng_finish), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct { logic care; logic [15:0] val; } exp_t;
  typedef struct { logic [4:0] idx; logic [15:0] val; } res_t;
  typedef struct { int idx; logic [15:0] data; } vec_t;

  exp_t        exp_q[$];
  res_t        res_q[$];
  logic [15:0] burst_log[$];
  vec_t        tbl[9];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ena_cnt = 0;
  int last_res_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int r, input int c);
    return 16'(r * 16 + c);
  endfunction

  task automatic push_pix(input int r, input int c);
    exp_t e;
    e.care = 1'b1;
    e.val  = pix(r, c);
    exp_q.push_back(e);
  endtask

  // Reference order written directly from the serpentine description.
  task automatic push_frame(input bit with_kernel, input bit kcare);
    exp_t e;
    if (with_kernel) begin
      for (int k = 1; k <= 9; k++) begin
        e.care = kcare;
        e.val  = 16'(k);
        exp_q.push_back(e);
      end
    end
    for (int c = 1; c <= 7; c++) for (int r = 1; r <= 3; r++) push_pix(r, c);
    for (int w = 2; w <= 5; w++) begin
      if (w % 2 == 0) begin
        for (int c = 5; c <= 7; c++) push_pix(w + 2, c);
        for (int c = 4; c >= 1; c--) for (int k = 0; k < 3; k++) push_pix(w + k, c);
      end else begin
        for (int c = 1; c <= 3; c++) push_pix(w + 2, c);
        for (int c = 4; c <= 7; c++) for (int k = 0; k < 3; k++) push_pix(w + k, c);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (eng_ena === 1'b1) begin
      ena_cnt++;
      burst_log.push_back(eng_data);
      check("eng_word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.care) check("eng_data", 32'(eng_data), 32'(e.val));
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (res_valid === 1'b1) begin
      last_res_cyc = cyc;
      check("res_expected", {31'd0, res_q.size() != 0}, 32'd1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        check("res_idx", 32'(res_idx), 32'(r.idx));
        check("res_data", 32'(res_data), 32'(r.val));
      end
    end
  end

  task automatic write_word(input logic [5:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic reuse);
    @(posedge clk); #1;
    start = 1'b1; reuse_kernel = reuse;
    burst_log.delete();
    ena_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0; reuse_kernel = 1'b0;
  endtask

  task automatic wait_burst_end(input string name);
    int n = 0;
    @(negedge clk);
    while (eng_ena === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(eng_ena), 32'd0);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_cyc;
    tbl[0] = '{0,  16'h0001};
    tbl[1] = '{8,  16'h0009};
    tbl[2] = '{9,  16'h0011};
    tbl[3] = '{10, 16'h0021};
    tbl[4] = '{11, 16'h0031};
    tbl[5] = '{12, 16'h0012};
    tbl[6] = '{30, 16'h0045};
    tbl[7] = '{45, 16'h0051};
    tbl[8] = '{89, 16'h0077};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    reuse_kernel = 1'b0; eng_valid = 1'b0; eng_result = '0; eng_finish = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_eng_ena", 32'(eng_ena), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_eng_data", 32'(eng_data), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_idx", 32'(res_idx), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame A: reuse requested but no kernel ever written -> full burst, silent engine.
    for (int r = 1; r <= 7; r++)
      for (int c = 1; c <= 7; c++) write_word(6'(9 + 7 * (r - 1) + (c - 1)), pix(r, c));
    push_frame(1'b1, 1'b0);
    do_start(1'b1);
    @(negedge clk);
    check("a_latency_ena", 32'(eng_ena), 1);
    check("a_latency_busy", 32'(busy), 1);
    wait_burst_end("a_burst_end");
    check("a_burst_len", 32'(ena_cnt), 32'd90);
    check("a_data_hold", 32'(eng_data), 32'h77);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_timeout_delay", 32'(n), 32'(DRAIN_MAX));
    check("a_timeout_err", 32'(err), 1);
    check("a_done_busy", 32'(busy), 0);
    @(negedge clk);
    check("a_done_pulse", 32'(done), 0);
    check("a_err_sticky", 32'(err), 1);
    check("a_stream_drained", 32'(exp_q.size()), 0);

    // Frame B: kernel loaded, engine returns 25 results during the tail of the burst.
    for (int k = 0; k < 9; k++) write_word(6'(k), 16'(k + 1));
    push_frame(1'b1, 1'b1);
    do_start(1'b0);
    @(negedge clk);
    check("b_err_cleared", 32'(err), 0);
    repeat (50) @(posedge clk);
    for (int i = 0; i < 25; i++) begin
      res_t r;
      #1;
      eng_valid = 1'b1;
      eng_result = 16'(16'h100 + i);
      r.idx = 5'(i);
      r.val = 16'(16'h100 + i);
      res_q.push_back(r);
      @(posedge clk); #1;
      eng_valid = 1'b0;
      @(posedge clk);
    end
    wait_done("b_done_seen", n);
    done_cyc = cyc;
    check("b_done_after_last_res", 32'(done_cyc - last_res_cyc), 32'd1);
    check("b_err", 32'(err), 0);
    check("b_burst_len", 32'(ena_cnt), 32'd90);
    check("b_res_all_seen", 32'(res_q.size()), 0);
    for (int i = 0; i < 9; i++) begin
      logic [31:0] got;
      got = 32'hFFFF_FFFF;
      if (burst_log.size() > tbl[i].idx) got = 32'(burst_log[tbl[i].idx]);
      check($sformatf("b_tbl_word%0d", tbl[i].idx), got, 32'(tbl[i].data));
    end
`ifdef CON_FEED_RESBUF_EN
    @(posedge clk); #1;
    rd_addr = 5'd7;
    @(posedge clk); #1;
    rd_addr = 5'd30;
    @(negedge clk);
    check("b_rd_data_7", 32'(rd_data), 32'h107);
    @(negedge clk);
    check("b_rd_data_oob", 32'(rd_data), 0);
`else
    @(posedge clk); #1;
    rd_addr = 5'd7;
    @(posedge clk);
    @(negedge clk);
    check("b_rd_data_tied", 32'(rd_data), 0);
`endif

    // Frame C: reuse kernel; writes/start/finish during the burst must be ignored.
    repeat (7) @(posedge clk);
    push_frame(1'b0, 1'b1);
    do_start(1'b1);
    @(negedge clk);
    check("c_first_word", 32'(eng_data), 32'h11);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 16'hBEEF;
    start = 1'b1; reuse_kernel = 1'b0; eng_finish = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; eng_finish = 1'b0;
    wait_burst_end("c_burst_end");
    check("c_burst_len", 32'(ena_cnt), 32'd81);
    check("c_still_busy", 32'(busy), 1);
    @(posedge clk); #1;
    eng_finish = 1'b1;
    @(posedge clk); #1;
    eng_finish = 1'b0;
    @(negedge clk);
    check("c_finish_done", 32'(done), 1);
    check("c_finish_err", 32'(err), 0);
    repeat (5) @(negedge clk);
    check("c_no_restart", 32'(ena_cnt), 32'd81);
    check("c_idle_busy", 32'(busy), 0);

    // Frame D: synchronous reset on pixel word 40.
    push_frame(1'b1, 1'b1);
    do_start(1'b0);
    repeat (48) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("d_rst_eng_ena", 32'(eng_ena), 0);
    check("d_rst_busy", 32'(busy), 0);
    check("d_rst_eng_data", 32'(eng_data), 0);
    check("d_rst_done", 32'(done), 0);
    check("d_words_before_rst", 32'(ena_cnt), 32'd49);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame E: kernel_loaded cleared by reset -> kernel phase again; buffer kept its data.
    push_frame(1'b1, 1'b1);
    do_start(1'b1);
    wait_burst_end("e_burst_end");
    check("e_burst_len", 32'(ena_cnt), 32'd90);
    check("e_busy_write_ignored", (burst_log.size() > 9) ? 32'(burst_log[9]) : 32'hFFFF_FFFF,
          32'h11);
    wait_done("e_done_seen", n);
    check("e_timeout_err", 32'(err), 1);
    check("e_stream_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
